// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: holds one 28x28 signed 8-bit image and streams its 5x5 windows to the CNN core.
// Build macro FEEDER_TIMEOUT_EN adds a DONE watchdog that returns class 4'hF and raises ERR.

module cnn_window_feeder #(
  parameter int IMG_W = 28
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         LOAD_WE,
  input  logic [9:0]   LOAD_ADDR,
  input  logic [7:0]   LOAD_DATA,
  input  logic         RUN,
  output logic         BUSY,
  output logic [3:0]   RESULT,
  output logic         RESULT_VALID,
  output logic         ERR,
  output logic         CNN_RSTN,
  output logic         START,
  output logic [4:0]   X,
  output logic [4:0]   Y,
  output logic [199:0] IMGIN,
  input  logic         DONE,
  input  logic [3:0]   OUT
);
  localparam int         DEPTH    = IMG_W * IMG_W;
  localparam logic [4:0] POS_LAST = 5'(IMG_W - 5);
  localparam logic [9:0] ADDR_LIM = 10'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STRT,
    S_ARM,
    S_STREAM,
    S_WAIT
  } state_e;

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic [3:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       cnn_rstn_q, cnn_rstn_d;
  logic       start_q, start_d;
  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;

  logic [7:0] mem [DEPTH];

  logic run_accept;
  logic done_hit;
  logic last_win;
  logic tmo_expire;

  assign run_accept = (state_q == S_IDLE) && RUN;
  assign done_hit   = (state_q == S_WAIT) && DONE;
  assign last_win   = (state_q == S_STREAM) && (x_q == POS_LAST) && (y_q == POS_LAST);

`ifdef FEEDER_TIMEOUT_EN
  logic [5:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + 6'd1 : 6'd0;
  end

  // A DONE landing on the expiry cycle takes priority over the timeout.
  assign tmo_expire = (state_q == S_WAIT) && (tmo_cnt_q == 6'd31) && !DONE;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (RUN) state_d = S_CLR;
      S_CLR:    state_d = S_STRT;
      S_STRT:   state_d = S_ARM;
      S_ARM:    state_d = S_STREAM;
      S_STREAM: if (last_win) state_d = S_WAIT;
      S_WAIT:   if (DONE || tmo_expire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values are decoded from the next state.
  always_comb begin
    busy_d     = busy_q;
    result_d   = result_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnn_rstn_d = (state_d != S_CLR);
    start_d    = (state_d == S_STRT);
    x_d        = 5'd0;
    y_d        = 5'd0;

    if (run_accept) begin
      busy_d  = 1'b1;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end

    if (done_hit) begin
      result_d = OUT;
      valid_d  = 1'b1;
      busy_d   = 1'b0;
    end else if (tmo_expire) begin
      result_d = 4'hF;
      valid_d  = 1'b1;
      err_d    = 1'b1;
      busy_d   = 1'b0;
    end

    if (state_d == S_STREAM && state_q == S_STREAM) begin
      if (x_q == POS_LAST) begin
        x_d = 5'd0;
        y_d = y_q + 5'd1;
      end else begin
        x_d = x_q + 5'd1;
        y_d = y_q;
      end
    end else if (state_d == S_WAIT) begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q     <= 1'b0;
      result_q   <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnn_rstn_q <= 1'b1;
      start_q    <= 1'b0;
      x_q        <= 5'd0;
      y_q        <= 5'd0;
    end else begin
      busy_q     <= busy_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnn_rstn_q <= cnn_rstn_d;
      start_q    <= start_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // NOTE: the image store has no reset so the picture survives an aborted run.
  always_ff @(posedge CLK) begin
    if (LOAD_WE && !busy_q && (LOAD_ADDR < ADDR_LIM)) mem[LOAD_ADDR] <= LOAD_DATA;
  end

  // Row r of the window occupies a 40-bit lane, leftmost pixel in the top byte.
  always_comb begin
    IMGIN = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        IMGIN[199 - 40*r - 8*c -: 8] = mem[10'((int'(y_q) + r) * IMG_W + int'(x_q) + c)];
      end
    end
  end

  assign BUSY         = busy_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = valid_q;
  assign ERR          = err_q;
  assign CNN_RSTN     = cnn_rstn_q;
  assign START        = start_q;
  assign X            = x_q;
  assign Y            = y_q;

endmodule
